// File: rtl/sbox_layer_seq.sv
// Ascon substitution layer (p_S) over the 320-bit state, applied NB_SBOX columns per cycle.
// A start/busy/done handshake lets the permutation FSM stall while the pass runs.
module sbox_layer_seq #(
  parameter int unsigned NB_SBOX = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int unsigned Chunks = 64 / NB_SBOX;
  localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Chunks - 1);

  if (NB_SBOX != 1 && NB_SBOX != 2 && NB_SBOX != 4 && NB_SBOX != 8 &&
      NB_SBOX != 16 && NB_SBOX != 32 && NB_SBOX != 64) begin : gen_bad_param
    $error("sbox_layer_seq: NB_SBOX must be a power of two in 1..64");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          fsm_q, fsm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [319:0]    work_q, work_d;
  logic [63:0]     lane_q [5];
  logic [63:0]     lane_d [5];
  logic [5:0]      col    [NB_SBOX];
  logic [4:0]      sb_in  [NB_SBOX];
  logic [4:0]      sb_out [NB_SBOX];

  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    unique case (x)
      5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
      5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
      5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
      5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
      5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
      5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
      5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
      5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  default: y = 5'h17;
    endcase
    return y;
  endfunction

  // Lane 0 is x0 (MSB of each column), lane 4 is x4.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      lane_q[i] = work_q[319-64*i -: 64];
    end
  end

  // Column mux feeding the shared sbox bank, selected by the chunk counter.
  always_comb begin
    for (int k = 0; k < NB_SBOX; k++) begin
      col[k]    = 6'(int'(cnt_q) * NB_SBOX + k);
      sb_in[k]  = {lane_q[0][col[k]], lane_q[1][col[k]], lane_q[2][col[k]],
                   lane_q[3][col[k]], lane_q[4][col[k]]};
      sb_out[k] = sbox(sb_in[k]);
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    work_d = work_q;
    lane_d = lane_q;
    unique case (fsm_q)
      StIdle: begin
        if (start_i) begin
          work_d = state_i;
          cnt_d  = '0;
          fsm_d  = StRun;
        end
      end
      StRun: begin
        for (int k = 0; k < NB_SBOX; k++) begin
          for (int i = 0; i < 5; i++) begin
            lane_d[i][col[k]] = sb_out[k][4-i];
          end
        end
        work_d = {lane_d[0], lane_d[1], lane_d[2], lane_d[3], lane_d[4]};
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          fsm_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        // Back-to-back start is accepted here without an idle bubble.
        if (start_i) begin
          work_d = state_i;
          cnt_d  = '0;
          fsm_d  = StRun;
        end else begin
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q  <= StIdle;
      cnt_q  <= '0;
      work_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      work_q <= work_d;
    end
  end

  assign state_o = work_q;
  assign busy_o  = (fsm_q == StRun);
  assign done_o  = (fsm_q == StDone);

endmodule
